// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/response bundle between a requester and the digit-serial adder.
interface digit_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/adder_digit.sv
// Combinational DIGIT-wide ripple slice built from 1-bit full-adder equations.
module adder_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// WIDTH-bit adder that reuses one DIGIT-wide slice over WIDTH/DIGIT cycles,
// with a start/busy/done handshake and held result, carry-out and overflow.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic                 clk,
    input logic                 rst,
    digit_serial_adder_if.slave bus
);
    localparam int unsigned DIG_SAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int unsigned NDIG     = WIDTH / DIG_SAFE;
    localparam int unsigned CW       = clog2_min1(NDIG);

    if ((DIGIT < 1) || ((WIDTH % DIG_SAFE) != 0)) begin : g_param_check
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state;
    state_e           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nx;
    logic             carry;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [DIGIT-1:0] dsum;
    logic             dco;
    logic             dc_msb;
    logic             last_c;
    logic             capture_c;
    logic             step_c;
    logic             finish_c;

    adder_digit #(.DIGIT(DIGIT)) u_slice (
        .x     (sa[DIGIT-1:0]),
        .y     (sb[DIGIT-1:0]),
        .ci    (carry),
        .s     (dsum),
        .co    (dco),
        .c_msb (dc_msb)
    );

    // New digit enters at the MSB end so the final digit lands in place.
    if (NDIG == 1) begin : g_single
        assign sr_nx = dsum;
    end else begin : g_multi
        assign sr_nx = {dsum, sr[WIDTH-1:DIGIT]};
    end

    assign last_c = (cnt == CW'(NDIG - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last_c) state_nx = DONE;
            DONE:    state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Start is honoured only outside RUN, which makes it a no-op while busy.
    always_comb begin
        capture_c = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        case (state)
            IDLE, DONE: capture_c = bus.start;
            RUN: begin
                step_c   = 1'b1;
                finish_c = last_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= (state_nx == RUN);
            done_r <= (state_nx == DONE);
            if (capture_c) begin
                sa    <= bus.a;
                sb    <= bus.b;
                carry <= bus.cin;
                cnt   <= '0;
            end else if (step_c) begin
                sa    <= sa >> DIGIT;
                sb    <= sb >> DIGIT;
                sr    <= sr_nx;
                carry <= dco;
                cnt   <= cnt + CW'(1);
                if (finish_c) begin
                    sum_r  <= sr_nx;
                    cout_r <= dco;
                    ovf_r  <= dc_msb ^ dco;
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle successor to the 1-bit behavioural full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using one DIGIT-wide ripple slice reused over WIDTH/DIGIT cycles.
- Start/busy/done handshake; result, carry-out and signed overflow are registered and held stable.
- Used where area matters more than latency (arithmetic datapaths, accumulators).

Parameters:
- WIDTH, 16, operand and sum width in bits; must be an integer multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 gives a pure bit-serial adder, DIGIT = WIDTH gives a single-cycle add.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; a, b, cin sampled on the edge where start=1 and state is IDLE or DONE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle onward
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  unsigned carry-out of the MSB
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (sync, rst=1 at an edge) clears busy, done, sum, cout and ovf to 0. State goes to IDLE and the digit counter to 0. This applies mid-operation: the in-flight add is discarded and no done pulse follows.
- NDIG = WIDTH/DIGIT. Counter width is clog2(NDIG), minimum 1.
- State IDLE: busy=0, done=0. start=1 captures a into shift register SA, b into SB and cin into the carry register, clears the counter, and goes to RUN.
- State RUN: busy=1. Each cycle:
  - The slice adds SA[DIGIT-1:0] + SB[DIGIT-1:0] + carry.
  - The slice sum digit shifts into the top of the partial-sum register SR from the MSB side. SA and SB shift right by DIGIT.
  - The carry register takes the slice carry-out. The counter increments.
- On the cycle where counter == NDIG-1:
  - Load sum with the final SR value, including the current digit.
  - Load cout with the slice carry-out.
  - Load ovf with slice carry-into-MSB XOR slice carry-out.
  - Go to DONE.
- State DONE: done=1, busy=0, lasts exactly one cycle.
  - start=1 in DONE begins a new operation (goes to RUN), giving back-to-back operation with no idle cycle.
  - Otherwise return to IDLE.
- Latency: start sampled at edge T gives done=1 in the cycle following edge T+NDIG. Throughput is one add per NDIG+1 cycles.
- start while busy=1 is ignored. Operands are not re-sampled and the running add is unaffected.
- sum, cout and ovf never change during RUN. They change only on the completion edge or on reset.
- Arithmetic is modulo 2^WIDTH. cout and ovf are both always produced; the caller picks the unsigned or signed view.
- DIGIT == WIDTH: RUN lasts one cycle (NDIG=1); behaviour is otherwise identical.
- Elaboration error if WIDTH % DIGIT != 0 or DIGIT < 1.

Decomposition:
- Shared package adder_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - clog2 function used to size the counter
- Sub-module adder_digit (combinational, parameter DIGIT):
  - inputs x[DIGIT], y[DIGIT], ci
  - outputs s[DIGIT], co, c_msb (carry into the slice MSB)
  - implemented as a ripple chain of the existing 1-bit full-adder equations
- Top level holds the FSM, counter, shift registers and result registers.

Test Plan:
- WIDTH=16, DIGIT=4: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0. done exactly 4 cycles after the start edge; busy high for 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Start with a=0x0003, b=0x0004; assert start again 2 cycles later with a=0xAAAA -> result sum=0x0007, second start ignored. Then start in the DONE cycle with a=0x0010, b=0x0020 -> sum=0x0030, done 4 cycles later.
- Start a=0x1111, b=0x2222, then rst=1 at cycle 2 -> next cycle busy=0, done=0, sum=0, cout=0. No done pulse afterwards.
- WIDTH=8, DIGIT=1: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0, latency 8 cycles. WIDTH=8, DIGIT=8: same operands -> identical result, latency 1 cycle.
- Random: 10k random (a, b, cin) for each of (16,4), (16,1), (16,16) -> compare sum, cout and ovf against a reference model; check sum is stable throughout every RUN.
